// File: rtl/truth_table_checker.sv
// truth_table_checker
// Walks every N-bit input vector through two implementations of the same
// function, compares their outputs after a settle delay and reports the
// mismatch count, the first failing vector and an overall pass flag.
module truth_table_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     vec,
    input  logic             dut_a,
    input  logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N-1:0]     first_err_vec
);

    // Settle counter only ever holds SETTLE-1, so size it for that value.
    localparam int              CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       vec_q, vec_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               fev_q, fev_d;
    logic [N-1:0]       fevec_q, fevec_d;

    // State and result registers; reset returns everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fevec_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevec_q <= fevec_d;
        end
    end

    // Next-state logic: sweep vectors, compare in SAMPLE, summarise in DONE.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevec_d = fevec_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    vec_d   = '0;
                    cnt_d   = CNT_RELOAD;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fevec_d = '0;
                    pass_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (dut_a != dut_b) begin
                    // Saturate rather than wrap so a large failure never reads as a small one.
                    if (err_q != '1) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!fev_q) begin
                        fev_d   = 1'b1;
                        fevec_d = vec_q;
                    end
                end
                if (vec_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N'(1);
                    cnt_d   = CNT_RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                // err_q already includes the last SAMPLE's result here.
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: status decoded from state, results straight from registers.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        vec             = vec_q;
        pass            = pass_q;
        err_count       = err_q;
        first_err_valid = fev_q;
        first_err_vec   = fevec_q;
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (N=2/SETTLE=1/CNT_W=8 and
// N=3/SETTLE=2/CNT_W=2) fed from random truth tables, checked against a
// table-difference model of the expected run outcome and timing.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 0: N=2, SETTLE=1, CNT_W=8
    logic       start0;
    logic [3:0] tta0, ttb0;
    logic [1:0] vec0, fevec0;
    logic       busy0, done0, pass0, fev0;
    logic [7:0] err0;
    logic       a0, b0;
    assign a0 = tta0[vec0];
    assign b0 = ttb0[vec0];

    truth_table_checker #(.N(2), .SETTLE(1), .CNT_W(8)) u_chk0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec(vec0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_valid(fev0), .first_err_vec(fevec0)
    );

    // Instance 1: N=3, SETTLE=2, CNT_W=2
    logic       start1;
    logic [7:0] tta1, ttb1;
    logic [2:0] vec1, fevec1;
    logic       busy1, done1, pass1, fev1;
    logic [1:0] err1;
    logic       a1, b1;
    assign a1 = tta1[vec1];
    assign b1 = ttb1[vec1];

    truth_table_checker #(.N(3), .SETTLE(2), .CNT_W(2)) u_chk1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1), .first_err_vec(fevec1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: a run's outcome is a function of the two truth tables alone.
    function automatic int diff_count(input logic [7:0] d);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(d[i]);
        return c;
    endfunction

    function automatic int first_diff(input logic [7:0] d);
        for (int i = 0; i < 8; i++) if (d[i]) return i;
        return 0;
    endfunction

    // Full run on instance 0 with cycle-accurate vec/done checks.
    task automatic run0(input logic [3:0] a, input logic [3:0] b, input bit inject);
        logic [7:0] d;
        int exp_cnt;
        tta0 = a;
        ttb0 = b;
        d = {4'b0000, a ^ b};
        exp_cnt = diff_count(d);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (inject && k == 2) start0 = 1'b1;
            if (inject && k == 3) start0 = 1'b0;
            if (k < 8) begin
                check("vec0_seq", 32'(vec0), 32'(k / 2));
                check("done0_early", 32'(done0), 32'd0);
                check("busy0_run", 32'(busy0), 32'd1);
            end else begin
                check("done0_pulse", 32'(done0), 32'd1);
                check("vec0_last", 32'(vec0), 32'd3);
            end
            @(negedge clk);
        end
        check("busy0_fall", 32'(busy0), 32'd0);
        check("done0_single", 32'(done0), 32'd0);
        check("err0", 32'(err0), 32'(exp_cnt));
        check("fev0", 32'(fev0), 32'(exp_cnt != 0));
        check("fevec0", 32'(fevec0), 32'(first_diff(d)));
        check("pass0", 32'(pass0), 32'(exp_cnt == 0));
        check("vec0_hold", 32'(vec0), 32'd3);
    endtask

    // Run on instance 1 with a bounded wait for done.
    task automatic run1(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        int exp_cnt;
        int cyc;
        tta1 = a;
        ttb1 = b;
        d = a ^ b;
        exp_cnt = diff_count(d);
        if (exp_cnt > 3) exp_cnt = 3;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("done1_latency", 32'(cyc), 32'd24);
        check("vec1_last", 32'(vec1), 32'd7);
        @(negedge clk);
        check("busy1_fall", 32'(busy1), 32'd0);
        check("err1_sat", 32'(err1), 32'(exp_cnt));
        check("fev1", 32'(fev1), 32'(d != 8'd0));
        check("fevec1", 32'(fevec1), 32'(first_diff(d)));
        check("pass1", 32'(pass1), 32'(d == 8'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ra, rb;
        logic [7:0] sa;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tta0 = '0; ttb0 = '0;
        tta1 = '0; ttb1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_vec0", 32'(vec0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_pass0", 32'(pass0), 32'd0);
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_fev0", 32'(fev0), 32'd0);
        check("rst_fevec0", 32'(fevec0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_err1", 32'(err1), 32'd0);
        rst_n = 1'b1;

        // Identical implementations of ~v[1]&v[0]
        run0(4'b0010, 4'b0010, 1'b0);
        // Implementation B stuck at 0: single mismatch at vector 01
        run0(4'b0010, 4'b0000, 1'b0);
        // Clean run right after a failing one must clear the stale results
        run0(4'b0010, 4'b0010, 1'b0);
        // start pulsed while busy must not disturb the sweep
        run0(4'b0110, 4'b1010, 1'b1);

        // Every vector differs on the narrow counter: saturates at 3
        sa = 8'($urandom);
        run1(sa, ~sa);
        run1(8'hA5, 8'hA5);

        // Reset mid-run after a mismatch has been recorded
        tta0 = 4'b0001;
        ttb0 = 4'b0000;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_err0", 32'(err0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec0", 32'(vec0), 32'd0);
        check("arst_busy0", 32'(busy0), 32'd0);
        check("arst_err0", 32'(err0), 32'd0);
        check("arst_fev0", 32'(fev0), 32'd0);
        check("arst_done0", 32'(done0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done0", 32'(done0), 32'd0);
        end
        rst_n = 1'b1;
        run0(4'b0010, 4'b0010, 1'b0);

        // Randomized truth tables
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom);
            run0(ra, rb, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) begin
            sa = 8'($urandom);
            run1(sa, ($urandom_range(0, 2) == 0) ? sa : 8'($urandom) ^ sa & 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
